clic_gateway: RTL and testbench
===============================

# clic_gateway

Per-source interrupt gateway that sits directly upstream of the CLIC target arbiter. It optionally synchronizes raw interrupt lines and applies per-source polarity and trigger mode (level or edge). It holds the pending bit for each source, and that bit drives the arbiter's `ip_i`. Edge-pending bits are cleared by the arbiter's one-cycle `claim_o` pulse or by software writes to `clicintip`.

## Interface
Parameters:
- `N_SOURCE`, 256: number of interrupt sources; must be ≥ 2.
- `SyncStages`, 2: synchronizer depth; must be ≥ 2. Used only when `CLIC_GATEWAY_SYNC_EN` is defined.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous reset, active-high.
- `intr_src_i`  in  N_SOURCE  raw interrupt lines.
- `trig_edge_i`  in  N_SOURCE  1 = edge-triggered, 0 = level-triggered; static config from the register file.
- `trig_pol_i`  in  N_SOURCE  1 = active-low / falling edge, 0 = active-high / rising edge.
- `claim_i`  in  N_SOURCE  claim pulse from the arbiter; at most one bit set per cycle.
- `sw_set_i`  in  N_SOURCE  software write of 1 to `clicintip`; one-cycle pulse.
- `sw_clr_i`  in  N_SOURCE  software write of 0 to `clicintip`; one-cycle pulse.
- `ip_o`  out  N_SOURCE  pending bits to the arbiter's `ip_i`; registered.

## Operation
- Per source, `s` denotes the synchronizer output, or `intr_src_i` directly when the sync is compiled out.
- `prev_q` holds `s` from the previous cycle.
- `act = s ^ trig_pol_i`
- `act_prev = prev_q ^ trig_pol_i`
- `edge = act & ~act_prev`
- Because polarity is applied to both samples, toggling `trig_pol_i` while `s` is steady never produces an edge.

Level mode (`trig_edge_i = 0`):
- `pend_d = act`.
- `claim_i`, `sw_set_i` and `sw_clr_i` are ignored.

Edge mode (`trig_edge_i = 1`):
- `pend_d = edge | sw_set_i | (pend_q & ~claim_i & ~sw_clr_i)`.
- Set sources (edge, sw_set) win over clear sources (claim, sw_clr) in the same cycle, so no edge is lost.

Mode switches:
- Level → edge: `pend_q` keeps its current value until claimed or cleared.
- Edge → level: `pend_q` follows `act` from the next edge of `clk_i`.

Output and reset:
- `ip_o = pend_q`.
- Reset clears all sync flops, `prev_q` and `pend_q`; `ip_o` = 0 during and after reset.
- Reset asserted mid-operation discards all pending state and in-flight synchronizer samples.
- An active-high line already high at reset release produces exactly one edge once it propagates through the sync. An active-low line low at reset release produces none.

## Timing
- Sync stage: `SyncStages` flops per bit. All flops update on the rising edge of `clk_i`.
- Input-to-output latency, measured from the first `clk_i` edge that samples a change on `intr_src_i` to the cycle in which `ip_o` reflects it:
  - with sync: `SyncStages + 1` cycles (3 by default);
  - without sync: 1 cycle.
- Clear latency: `claim_i` or `sw_clr_i` in cycle t gives `ip_o` = 0 in cycle t+1.
- Set latency: `sw_set_i` in cycle t gives `ip_o` = 1 in cycle t+1.
- The arbiter sees `ip_o` drop exactly one cycle after its `claim_o` pulse, matching its single-cycle `CLAIM` state.
- Edge pulses narrower than one clock period may be missed; in sync mode the minimum reliable pulse width is one clock period.

## Configuration
- Macro: `CLIC_GATEWAY_SYNC_EN`.
- Defined: a `SyncStages`-deep synchronizer is inserted per source; `intr_src_i` may be asynchronous.
- Undefined: `s = intr_src_i` with no flops; inputs must be synchronous to `clk_i`, and latency drops to 1 cycle.
- All other behaviour is identical in both builds.

## Test plan
- Rising edge and claim (source 5, edge mode, pol 0, sync enabled):
  - Raise `intr_src_i[5]` at cycle 10 → `ip_o[5]` = 1 at cycle 13.
  - `claim_i[5]` at cycle 20 → `ip_o[5]` = 0 at cycle 21, line still high.
  - No re-set while the line stays high.
- Active-low level (source 3, level mode, pol 1):
  - Drive the line low → `ip_o[3]` = 1 after `SyncStages+1` cycles.
  - Pulse `claim_i[3]` and `sw_clr_i[3]` → `ip_o[3]` stays 1.
  - Drive the line high → `ip_o[3]` = 0 after `SyncStages+1` cycles.
- Set/clear collision (edge mode):
  - A new edge reaches the edge detector in the same cycle as `claim_i` → `ip_o` remains 1.
  - `sw_set_i` and `sw_clr_i` in the same cycle → `ip_o` = 1.
- Polarity toggle (edge mode, line held high):
  - Flip `trig_pol_i` 0→1→0 → `ip_o` never asserts.
- Reset mid-operation:
  - Assert `rst_i` for 1 cycle with 8 sources pending and edges still in the synchronizer → all `ip_o` = 0 from the next cycle.
  - Post-reset behaviour follows the reset-release rule above.
- Non-sync build (macro undefined):
  - Rising edge sampled at cycle t → `ip_o` = 1 at cycle t+1.

Source files
------------

// File: rtl/clic_gateway.sv
// Per-source CLIC interrupt gateway: optional input sync, polarity, level/edge pending.
// Optional synchronizer enabled by defining CLIC_GATEWAY_SYNC_EN.
module clic_gateway #(
  parameter int unsigned N_SOURCE   = 256,
  parameter int unsigned SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] intr_src_i,
  input  logic [N_SOURCE-1:0] trig_edge_i,
  input  logic [N_SOURCE-1:0] trig_pol_i,
  input  logic [N_SOURCE-1:0] claim_i,
  input  logic [N_SOURCE-1:0] sw_set_i,
  input  logic [N_SOURCE-1:0] sw_clr_i,
  output logic [N_SOURCE-1:0] ip_o
);

  logic [N_SOURCE-1:0] s;
  logic [N_SOURCE-1:0] prev_q;
  logic [N_SOURCE-1:0] pend_q, pend_d;
  logic [N_SOURCE-1:0] act, act_prev, edge_det;

  if (N_SOURCE < 2 || SyncStages < 2) begin : g_bad_param
    $error("clic_gateway: N_SOURCE and SyncStages must both be >= 2");
  end

`ifdef CLIC_GATEWAY_SYNC_EN
  logic [N_SOURCE-1:0] sync_q [SyncStages];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SyncStages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= intr_src_i;
      for (int unsigned i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SyncStages-1];
`else
  assign s = intr_src_i;
`endif

  // Polarity applied to both samples so a polarity flip on a steady line is not an edge.
  always_comb begin
    act      = s ^ trig_pol_i;
    act_prev = prev_q ^ trig_pol_i;
    edge_det = act & ~act_prev;
    pend_d   = (trig_edge_i & (edge_det | sw_set_i | (pend_q & ~claim_i & ~sw_clr_i)))
             | (~trig_edge_i & act);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= s;
      pend_q <= pend_d;
    end
  end

  assign ip_o = pend_q;

endmodule

// File: tb/tb_clic_gateway.sv
// Directed self-checking bench for clic_gateway (16 sources); latency follows CLIC_GATEWAY_SYNC_EN.
module tb_clic_gateway;

  localparam int unsigned N    = 16;
  localparam int unsigned SYNC = 2;
`ifdef CLIC_GATEWAY_SYNC_EN
  localparam int unsigned LAT = SYNC + 1;
`else
  localparam int unsigned LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] intr, trig_edge, trig_pol, claim, sw_set, sw_clr;
  logic [N-1:0] ip;

  int errors = 0;
  int checks = 0;

  clic_gateway #(.N_SOURCE(N), .SyncStages(SYNC)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .intr_src_i (intr),
    .trig_edge_i(trig_edge),
    .trig_pol_i (trig_pol),
    .claim_i    (claim),
    .sw_set_i   (sw_set),
    .sw_clr_i   (sw_clr),
    .ip_o       (ip)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_vec(input string tag, input logic [N-1:0] exp);
    checks++;
    assert (ip === exp) else begin
      errors++;
      $error("FAIL %s: ip_o=%h expected=%h", tag, ip, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input int unsigned idx, input logic exp);
    checks++;
    assert (ip[idx] === exp) else begin
      errors++;
      $error("FAIL %s: ip_o[%0d]=%b expected=%b", tag, idx, ip[idx], exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    intr      = 16'h0008;
    trig_edge = 16'hFFF7;
    trig_pol  = 16'h0008;
    claim     = '0;
    sw_set    = '0;
    sw_clr    = '0;
    tick(2);
    chk_vec("reset_hold", '0);
    rst = 1'b0;
    tick(5);
    chk_vec("after_reset", '0);

    // Rising edge and claim on source 5
    intr[5] = 1'b1;
    tick(LAT - 1);
    chk_bit("edge5_before_latency", 5, 1'b0);
    tick(1);
    chk_bit("edge5_set", 5, 1'b1);
    tick(3);
    chk_bit("edge5_hold", 5, 1'b1);
    claim[5] = 1'b1;
    tick(1);
    claim[5] = 1'b0;
    chk_bit("edge5_claimed", 5, 1'b0);
    tick(4);
    chk_bit("edge5_no_reset", 5, 1'b0);

    // Active-low level on source 3
    intr[3] = 1'b0;
    tick(LAT - 1);
    chk_bit("lvl3_before_latency", 3, 1'b0);
    tick(1);
    chk_bit("lvl3_active", 3, 1'b1);
    claim[3] = 1'b1;
    sw_clr[3] = 1'b1;
    tick(1);
    claim[3] = 1'b0;
    sw_clr[3] = 1'b0;
    chk_bit("lvl3_ignore_clear", 3, 1'b1);
    intr[3] = 1'b1;
    tick(LAT - 1);
    chk_bit("lvl3_release_latency", 3, 1'b1);
    tick(1);
    chk_bit("lvl3_inactive", 3, 1'b0);

    // Edge arriving together with claim on source 7
    intr[7] = 1'b1;
    tick(LAT);
    chk_bit("edge7_first", 7, 1'b1);
    intr[7] = 1'b0;
    tick(LAT + 1);
    chk_bit("edge7_fall_keeps", 7, 1'b1);
    intr[7] = 1'b1;
    tick(LAT - 1);
    claim[7] = 1'b1;
    tick(1);
    claim[7] = 1'b0;
    chk_bit("edge7_claim_collision", 7, 1'b1);
    claim[7] = 1'b1;
    tick(1);
    claim[7] = 1'b0;
    chk_bit("edge7_claim_alone", 7, 1'b0);

    // Software set/clear on source 9
    sw_set[9] = 1'b1;
    sw_clr[9] = 1'b1;
    tick(1);
    sw_set[9] = 1'b0;
    sw_clr[9] = 1'b0;
    chk_bit("sw9_set_clr_collision", 9, 1'b1);
    sw_clr[9] = 1'b1;
    tick(1);
    sw_clr[9] = 1'b0;
    chk_bit("sw9_clr", 9, 1'b0);
    sw_set[9] = 1'b1;
    tick(1);
    sw_set[9] = 1'b0;
    chk_bit("sw9_set", 9, 1'b1);
    claim[9] = 1'b1;
    tick(1);
    claim[9] = 1'b0;
    chk_bit("sw9_claim", 9, 1'b0);

    // Polarity toggle on a steady high line, source 11
    intr[11] = 1'b1;
    tick(LAT);
    chk_bit("pol11_initial_edge", 11, 1'b1);
    claim[11] = 1'b1;
    tick(1);
    claim[11] = 1'b0;
    chk_bit("pol11_claimed", 11, 1'b0);
    trig_pol[11] = 1'b1;
    tick(LAT + 1);
    chk_bit("pol11_to_low", 11, 1'b0);
    trig_pol[11] = 1'b0;
    tick(LAT + 1);
    chk_bit("pol11_back_high", 11, 1'b0);
    chk_vec("all_quiet", '0);

    // Reset with 8 pending sources and fresh edges in flight
    sw_set = 16'h1557;
    tick(1);
    sw_set = '0;
    chk_vec("eight_pending", 16'h1557);
    intr[13] = 1'b1;
    intr[14] = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk_vec("mid_reset_cleared", '0);
    rst = 1'b0;
    tick(LAT);
    chk_vec("post_reset_edges", 16'h68A0);
    tick(3);
    chk_vec("post_reset_single_edge", 16'h68A0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
